// File: rtl/final385_btn_pkg.sv
// Shared register map, default debounce length and debounce state type for
// the push-button/switch controller (debounce built with FINAL385_BTN_DEBOUNCE_EN).
package final385_btn_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // 10 ms at 50 MHz
    localparam int unsigned DB_CYCLES_DEFAULT = 500000;

    typedef enum logic {
        DB_STABLE,
        DB_COUNTING
    } db_state_e;

endpackage

// File: rtl/final385_btn_debounce.sv
// Single-bit input conditioner: two-flop synchroniser followed by a debounce
// counter when FINAL385_BTN_DEBOUNCE_EN is defined, else a plain synchroniser.
module final385_btn_debounce
    import final385_btn_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic level_o
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef FINAL385_BTN_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    // cnt counts consecutive mismatching samples; the DB_CYCLES-th one commits
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        unique case (state_q)
            DB_STABLE: begin
                if (sync2_q != level_q) begin
                    state_d = DB_COUNTING;
                    cnt_d   = CW'(1);
                end
            end
            DB_COUNTING: begin
                if (sync2_q == level_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_d = sync2_q;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    assign level_o = level_q;
`else
    assign level_o = sync2_q;
`endif

endmodule

// File: rtl/final385_soc_btn_ctrl.sv
// Avalon-MM button/switch controller: per-bit conditioning, edge capture with
// W1C clear and maskable level IRQ. Debounce enabled by FINAL385_BTN_DEBOUNCE_EN.
module final385_soc_btn_ctrl
    import final385_btn_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0] cap_set, cap_clr;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr_en;
    logic             unused_bus;

    // readdata is free-running, so the read strobe carries no information
    assign unused_bus = ^{read, writedata};

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        final385_btn_debounce #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .din_i  (in_port[i]),
            .level_o(level[i])
        );
    end

    assign wr_en = chipselect & write;

    always_comb begin
        edge_sel_d = edge_sel_q;
        irq_mask_d = irq_mask_q;
        if (wr_en && address == ADDR_EDGE_SEL) edge_sel_d = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_IRQ_MASK) irq_mask_d = writedata[WIDTH-1:0];

        cap_set = ((level & ~prev_q) & ~edge_sel_q) | ((~level & prev_q) & edge_sel_q);
        cap_clr = (wr_en && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
        // set is OR-ed after the clear so a same-cycle capture survives W1C
        edge_cap_d = (edge_cap_q & ~cap_clr) | cap_set;

        irq_d = |(edge_cap_d & irq_mask_d);

        unique case (address)
            ADDR_DATA:     readdata_d = 32'(level);
            ADDR_EDGE_SEL: readdata_d = 32'(edge_sel_q);
            ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
            ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q     <= '0;
            edge_sel_q <= '0;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prev_q     <= level;
            edge_sel_q <= edge_sel_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_final385_soc_btn_ctrl.sv
// Self-checking bench for final385_soc_btn_ctrl with a behavioural model that
// follows FINAL385_BTN_DEBOUNCE_EN the same way the design does.
module tb_final385_soc_btn_ctrl;

    localparam int W  = 4;
    localparam int DB = 4;
`ifdef FINAL385_BTN_DEBOUNCE_EN
    localparam int LAT = 2 + DB + 1;
`else
    localparam int LAT = 2 + 1;
`endif

    logic          clk;
    logic          reset_n;
    logic [1:0]    address;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic          irq;

    int vectors = 0;
    int errs    = 0;
    bit run_chk = 0;

    final385_soc_btn_ctrl #(
        .WIDTH    (W),
        .DB_CYCLES(DB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: inputs delayed two samples; a level flips once DB consecutive
    // delayed samples all disagree with it; edges derive from level history.
    logic [W-1:0] m_s1, m_s2, m_lvl, m_prev, m_cap, m_sel, m_mask;
    logic [31:0]  m_rd;
    logic         m_irq;
`ifdef FINAL385_BTN_DEBOUNCE_EN
    logic [W-1:0] m_hist [DB];
`endif

    assign m_irq = |(m_cap & m_mask);

    always @(posedge clk or negedge reset_n) begin : model
        logic [W-1:0] c_set, c_clr, lvl_n;
        logic         wr;
`ifdef FINAL385_BTN_DEBOUNCE_EN
        logic [W-1:0] h [DB];
        logic         flip;
`endif
        if (!reset_n) begin
            m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_prev <= '0;
            m_cap <= '0; m_sel <= '0; m_mask <= '0; m_rd <= '0;
`ifdef FINAL385_BTN_DEBOUNCE_EN
            for (int k = 0; k < DB; k++) m_hist[k] <= '0;
`endif
        end else begin
            wr = chipselect & write;
            case (address)
                2'd0: m_rd <= 32'(m_lvl);
                2'd1: m_rd <= 32'(m_sel);
                2'd2: m_rd <= 32'(m_mask);
                default: m_rd <= 32'(m_cap);
            endcase
            c_set = 0;
            for (int i = 0; i < W; i++) begin
                if (!m_sel[i] && m_lvl[i] && !m_prev[i]) c_set[i] = 1'b1;
                if (m_sel[i] && !m_lvl[i] && m_prev[i])  c_set[i] = 1'b1;
            end
            c_clr = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            m_cap <= (m_cap & ~c_clr) | c_set;
            if (wr && address == 2'd1) m_sel  <= writedata[W-1:0];
            if (wr && address == 2'd2) m_mask <= writedata[W-1:0];
            m_prev <= m_lvl;
`ifdef FINAL385_BTN_DEBOUNCE_EN
            h[0] = m_s2;
            for (int k = 1; k < DB; k++) h[k] = m_hist[k-1];
            for (int k = 0; k < DB; k++) m_hist[k] <= h[k];
            lvl_n = m_lvl;
            for (int i = 0; i < W; i++) begin
                flip = 1'b1;
                for (int k = 0; k < DB; k++) if (h[k][i] == m_lvl[i]) flip = 1'b0;
                if (flip) lvl_n[i] = ~m_lvl[i];
            end
`else
            lvl_n = m_s1;
`endif
            m_lvl <= lvl_n;
            m_s2  <= m_s1;
            m_s1  <= in_port;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && run_chk) begin
            check("model_readdata", readdata, m_rd);
            check("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic wr_reg(input int a, input logic [31:0] d);
        address    = 2'(a);
        writedata  = d;
        chipselect = 1'b1;
        write      = 1'b1;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic rd_expect(input int a, input logic [31:0] exp, input string name);
        address = 2'(a);
        @(negedge clk);
        check(name, readdata, exp);
    endtask

    task automatic settle();
        repeat (LAT + 2) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0;
        write = 1'b0; writedata = '0; in_port = '0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        run_chk = 1'b1;

        // reset state
        for (int a = 0; a < 4; a++) rd_expect(a, 32'h0, "reset_read");
        check("reset_irq", 32'(irq), 32'h0);

        // clean press: DATA visible exactly LAT cycles after the input step
        address = 2'd0;
        in_port = 4'b0001;
        repeat (LAT - 1) @(negedge clk);
        check("press_data_early", readdata, 32'h0);
        @(negedge clk);
        check("press_data", readdata, 32'h1);
        rd_expect(3, 32'h1, "press_cap");
        wr_reg(2, 32'h1);
        check("press_irq_masked_in", 32'(irq), 32'h1);
        wr_reg(2, 32'h0);
        check("press_irq_masked_out", 32'(irq), 32'h0);
        wr_reg(3, 32'hF);
        in_port = '0;
        settle();

        // glitch on bit 2
        wr_reg(2, 32'hF);
        in_port = 4'b0100;
        repeat (3) @(negedge clk);
        in_port = '0;
        repeat (10) @(negedge clk);
`ifdef FINAL385_BTN_DEBOUNCE_EN
        rd_expect(0, 32'h0, "glitch_data");
        rd_expect(3, 32'h0, "glitch_cap");
        check("glitch_irq", 32'(irq), 32'h0);
`endif
        wr_reg(3, 32'hF);

        // falling-edge select on bit 3
        wr_reg(1, 32'h8);
        in_port = 4'b1000;
        repeat (10) @(negedge clk);
        in_port = '0;
        rd_expect(3, 32'h0, "fall_press_cap");
        repeat (LAT + 2) @(negedge clk);
        rd_expect(3, 32'h8, "fall_release_cap");
        wr_reg(3, 32'hF);
        wr_reg(1, 32'h0);

        // W1C racing a new bit-0 capture
        in_port = 4'b0011;
        settle();
        rd_expect(3, 32'h3, "race_pre_cap");
        in_port = 4'b0010;
        settle();
        in_port = 4'b0011;
        repeat (LAT - 1) @(negedge clk);
        wr_reg(3, 32'h3);
        check("race_irq", 32'(irq), 32'h1);
        rd_expect(3, 32'h1, "race_cap");
        wr_reg(3, 32'hF);
        in_port = '0;
        settle();

        // reset in the middle of a count
        address = 2'd0;
        in_port = 4'b0010;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("midrst_data_early", readdata, 32'h0);
        @(negedge clk);
        check("midrst_data", readdata, 32'h2);
        rd_expect(3, 32'h2, "midrst_cap");

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(5) == 0) begin
                int b;
                b = int'($urandom_range(W - 1));
                in_port[b] = ~in_port[b];
            end
            address    = 2'($urandom_range(3));
            chipselect = 1'($urandom_range(1));
            write      = ($urandom_range(3) == 0);
            read       = ~write;
            writedata  = $urandom;
            @(negedge clk);
        end
        chipselect = 1'b0;
        write      = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/final385_soc_btn_ctrl.md
# final385_soc_btn_ctrl

Avalon-MM slave input controller for the board push-buttons and switches. It replaces the bare input PIO path with four stages: per-bit synchronisation, optional debouncing, edge capture and a maskable interrupt. It sits on the Nios II data bus inside final385_soc. Software reads clean button levels from it and receives one IRQ per qualified press, so it no longer polls the raw pins.

## Interface
- WIDTH, 4: number of input bits, 1..32.
- DB_CYCLES, 500000: consecutive stable cycles required to accept a new level (10 ms at 50 MHz); must be ≥2.
- clk  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  2  register word address.
- chipselect  in  1  slave select.
- read  in  1  read strobe (qualifies nothing; readdata is free-running).
- write  in  1  write strobe, effective only with chipselect.
- writedata  in  32  write data.
- readdata  out  32  registered read data, zero-extended above WIDTH.
- in_port  in  WIDTH  raw asynchronous inputs.
- irq  out  1  level interrupt to CPU.

## Operation
- Register map:
  - 0 DATA (RO): debounced levels.
  - 1 EDGE_SEL (RW): per bit, 0 = capture rising, 1 = capture falling.
  - 2 IRQ_MASK (RW).
  - 3 EDGE_CAP (RO, W1C).
- Writes to DATA are ignored. Writes store writedata[WIDTH-1:0]; upper bits are ignored.
- Synchroniser: 2 flops per bit, reset 0.
- Debounce, per bit, states STABLE and COUNTING:
  - STABLE: if sync ≠ level, go to COUNTING with cnt=1.
  - COUNTING: if sync == level, return to STABLE and clear cnt. Otherwise increment cnt.
  - COUNTING, cnt == DB_CYCLES-1 while mismatch persists: level ← sync, go to STABLE, cnt ← 0.
- A glitch shorter than DB_CYCLES never changes level.
- Edge detect: prev ← level every cycle.
  - rise = level & ~prev; fall = ~level & prev.
  - A selected edge sets EDGE_CAP[i].
- W1C: a write to addr 3 clears each bit with writedata[i]=1. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq = |(EDGE_CAP & IRQ_MASK), driven from flops only. It stays asserted until software clears the bits or masks them.
- Changing EDGE_SEL does not create an edge and does not alter EDGE_CAP.
- Reset values: readdata, EDGE_SEL, IRQ_MASK, EDGE_CAP, level, prev, counters, synchronisers and irq are all 0. Reset mid-count abandons the count.
- Buttons that are held at reset read 1 once debounced. This produces a rising edge in EDGE_CAP, and software clears it at init.

## Timing
- readdata: updated every clk from the current address. One-cycle read latency (readLatency=1).
- Write takes effect on the clk edge where chipselect & write are high. A read of the same register in the next cycle returns the new value.
- in_port step, held stable, to DATA visible in readdata: 2 (sync) + DB_CYCLES + 1 (read register) cycles.
- EDGE_CAP bit and irq assert 1 cycle after level changes.
- Write-clear to irq deassertion: irq drops the cycle after the write edge.

## Configuration
- FINAL385_BTN_DEBOUNCE_EN defined: the debounce stage is present as above.
- Not defined:
  - level = synchroniser output directly.
  - DB_CYCLES is ignored and no counters are built.
  - in_port to DATA latency becomes 2 + 1 cycles.
  - Edge behaviour is otherwise identical.

## Structure
- Package final385_btn_pkg holds:
  - register address localparams: ADDR_DATA=0, ADDR_EDGE_SEL=1, ADDR_IRQ_MASK=2, ADDR_EDGE_CAP=3;
  - default DB_CYCLES;
  - debounce state enum {DB_STABLE, DB_COUNTING}.
- Sub-module final385_btn_debounce handles a single bit: synchroniser, counter and state, with output level. It is instantiated WIDTH times under a generate.
- Counter width is $clog2(DB_CYCLES).

## Test plan
Bench uses DB_CYCLES=4.
- Reset: after reset_n release, irq=0 and readdata=0 at every address.
- Clean press: in_port 0000→0001 held. DATA reads 0x1 at cycle 2+4+1. EDGE_CAP=0x1. irq=1 with IRQ_MASK=0x1, irq=0 with IRQ_MASK=0.
- Glitch: bit 2 high for 3 cycles then low. DATA stays 0, EDGE_CAP stays 0, irq stays 0.
- Falling select: EDGE_SEL=0x8; bit 3 pulses high for 10 cycles. EDGE_CAP[3] sets only on the release, not the press.
- W1C race: EDGE_CAP=0x3; write 0x3 to addr 3 in the same cycle a new bit-0 edge is captured. Result EDGE_CAP=0x1 and irq stays 1 if bit 0 is masked in.
- Mid-count reset: bit 1 toggles; assert reset_n at count 2 and release. DATA=0 and no edge is captured until a full 4-cycle stable period has elapsed.
